// File: rtl/breg_arb_pkg.sv
// Shared types and constants for the register-bank access arbiter.
// Imported by the arbiter top and its round-robin picker.
package breg_arb_pkg;

    localparam int DEF_AW   = 5;
    localparam int DEF_DW   = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/breg_access_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    logic [PW:0] w_k;
    logic        w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            w_k = {1'b0, i_ptr} + (PW+1)'(i);
            if (w_k >= (PW+1)'(N))
                w_k = w_k - (PW+1)'(N);
            if (!w_found && i_req[w_k[PW-1:0]]) begin
                w_found               = 1'b1;
                o_grant[w_k[PW-1:0]] = 1'b1;
                o_idx                = w_k[PW-1:0];
            end
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/breg_access_arbiter.sv
// Round-robin arbiter sharing the register bank ports between requesters.
// Each transaction runs IDLE (arbitrate) -> ISSUE (bank access) -> DONE (ack).
module breg_access_arbiter
    import breg_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DW           = DEF_DW,
    parameter int AW           = DEF_AW,
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_ra1,
    input  logic [NUM_REQ*AW-1:0] req_ra2,
    input  logic [NUM_REQ*AW-1:0] req_wa,
    input  logic [NUM_REQ*DW-1:0] req_wd,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DW-1:0]         rd1,
    output logic [DW-1:0]         rd2,
    output logic                  zero_drop,
    output logic [AW-1:0]         ReadReg1,
    output logic [AW-1:0]         ReadReg2,
    output logic [AW-1:0]         WriteRegister,
    output logic [DW-1:0]         WriteData,
    output logic                  enesc,
    input  logic [DW-1:0]         ReadData1,
    input  logic [DW-1:0]         ReadData2
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               r_state;
    state_t               w_next;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_win;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_we;
    logic [AW-1:0]        r_ra1;
    logic [AW-1:0]        r_ra2;
    logic [AW-1:0]        r_wa;
    logic [DW-1:0]        r_wd;
    logic [DW-1:0]        r_rd1;
    logic [DW-1:0]        r_rd2;

    logic [NUM_REQ-1:0]   w_pick_gnt;
    logic [PW-1:0]        w_pick_idx;
    logic                 w_any;
    logic                 w_zero;
    logic                 w_enesc;
    logic                 w_zd;
    logic [NUM_REQ-1:0]   w_ack;

    rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_any   (w_any)
    );

    assign w_zero = ZERO_PROTECT && (r_wa == AW'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_enesc = 1'b0;
        w_zd    = 1'b0;
        w_ack   = '0;
        unique case (r_state)
            IDLE: begin
                if (w_any)
                    w_next = ISSUE;
            end
            ISSUE: begin
                w_next  = DONE;
                w_enesc = r_we && !w_zero;
            end
            DONE: begin
                w_next = IDLE;
                w_ack  = r_gnt;
                w_zd   = r_we && w_zero;
            end
            default: w_next = IDLE;
        endcase
    end

    // Payload is latched once at arbitration; later changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
            r_gnt <= '0;
            r_we  <= 1'b0;
            r_ra1 <= '0;
            r_ra2 <= '0;
            r_wa  <= '0;
            r_wd  <= '0;
        end else if (r_state == IDLE && w_any) begin
            r_win <= w_pick_idx;
            r_gnt <= w_pick_gnt;
            r_we  <= req_we[w_pick_idx];
            r_ra1 <= req_ra1[int'(w_pick_idx)*AW +: AW];
            r_ra2 <= req_ra2[int'(w_pick_idx)*AW +: AW];
            r_wa  <= req_wa[int'(w_pick_idx)*AW +: AW];
            r_wd  <= req_wd[int'(w_pick_idx)*DW +: DW];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
            r_ptr <= '0;
        end else begin
            if (r_state == ISSUE) begin
                r_rd1 <= ReadData1;
                r_rd2 <= ReadData2;
            end
            if (r_state == DONE)
                r_ptr <= (r_win == PW'(NUM_REQ-1)) ? '0 : r_win + 1'b1;
        end
    end

    assign ack           = w_ack;
    assign zero_drop     = w_zd;
    assign enesc         = w_enesc;
    assign rd1           = r_rd1;
    assign rd2           = r_rd2;
    assign ReadReg1      = r_ra1;
    assign ReadReg2      = r_ra2;
    assign WriteRegister = r_wa;
    assign WriteData     = r_wd;

endmodule

// File: tb/tb_breg_access_arbiter.sv
// Directed bench for breg_access_arbiter with a write-first bank model;
// a second instance with ZERO_PROTECT=0 runs in lockstep.
module tb_breg_access_arbiter;

    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_ra1 = '0;
    logic [N*AW-1:0] req_ra2 = '0;
    logic [N*AW-1:0] req_wa = '0;
    logic [N*DW-1:0] req_wd = '0;

    logic [N-1:0]  ack, ack0;
    logic [DW-1:0] rd1, rd2, rd1_0, rd2_0;
    logic          zd, zd0, en, en0;
    logic [AW-1:0] rr1, rr2, wr, rr1_0, rr2_0, wr0;
    logic [DW-1:0] wd, wd0, bd1, bd2, bd1_0, bd2_0;

    logic [DW-1:0] bank  [32];
    logic [DW-1:0] bank0 [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    breg_access_arbiter #(.NUM_REQ(N), .DW(DW), .AW(AW), .ZERO_PROTECT(1'b1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we),
        .req_ra1(req_ra1), .req_ra2(req_ra2), .req_wa(req_wa), .req_wd(req_wd),
        .ack(ack), .rd1(rd1), .rd2(rd2), .zero_drop(zd),
        .ReadReg1(rr1), .ReadReg2(rr2), .WriteRegister(wr), .WriteData(wd),
        .enesc(en), .ReadData1(bd1), .ReadData2(bd2)
    );

    breg_access_arbiter #(.NUM_REQ(N), .DW(DW), .AW(AW), .ZERO_PROTECT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we),
        .req_ra1(req_ra1), .req_ra2(req_ra2), .req_wa(req_wa), .req_wd(req_wd),
        .ack(ack0), .rd1(rd1_0), .rd2(rd2_0), .zero_drop(zd0),
        .ReadReg1(rr1_0), .ReadReg2(rr2_0), .WriteRegister(wr0), .WriteData(wd0),
        .enesc(en0), .ReadData1(bd1_0), .ReadData2(bd2_0)
    );

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                bank[i]  <= 32'(i);
                bank0[i] <= 32'(i);
            end
        end else begin
            if (en)  bank[wr]   <= wd;
            if (en0) bank0[wr0] <= wd0;
        end
    end

    assign bd1   = (en && wr == rr1) ? wd : bank[rr1];
    assign bd2   = (en && wr == rr2) ? wd : bank[rr2];
    assign bd1_0 = (en0 && wr0 == rr1_0) ? wd0 : bank0[rr1_0];
    assign bd2_0 = (en0 && wr0 == rr2_0) ? wd0 : bank0[rr2_0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] wa,
                           input logic [DW-1:0] d);
        req_we[i]         = we;
        req_ra1[i*AW +: AW] = a1;
        req_ra2[i*AW +: AW] = a2;
        req_wa[i*AW +: AW]  = wa;
        req_wd[i*DW +: DW]  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (ack !== 2'b00 || zd !== 1'b0 || en !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl got ack=%b zd=%b en=%b exp 00 0 0", ack, zd, en);
        end
        total++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_rd got %h %h exp 0 0", rd1, rd2);
        end
        total++;
        if (rr1 !== 5'd0 || rr2 !== 5'd0 || wr !== 5'd0 || wd !== 32'h0) begin
            bad++;
            $display("FAIL reset_bank got %0d %0d %0d %h exp 0", rr1, rr2, wr, wd);
        end
        rst = 1'b0;
        tick();
        total++;
        if (ack !== 2'b00 || en !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got ack=%b en=%b exp 00 0", ack, en);
        end
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 5'd5, 5'd1, 5'd5, 32'hDEADBEEF);
        req = 2'b01;
        tick();
        total++;
        if (en !== 1'b1 || wr !== 5'd5 || wd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_issue got en=%b wr=%0d wd=%h exp 1 5 deadbeef", en, wr, wd);
        end
        total++;
        if (ack !== 2'b00) begin
            bad++;
            $display("FAIL single_early_ack got %b exp 00", ack);
        end
        tick();
        total++;
        if (ack !== 2'b01 || en !== 1'b0) begin
            bad++;
            $display("FAIL single_ack got ack=%b en=%b exp 01 0", ack, en);
        end
        total++;
        if (rd1 !== 32'hDEADBEEF || rd2 !== 32'h1) begin
            bad++;
            $display("FAIL single_rd got %h %h exp deadbeef 00000001", rd1, rd2);
        end
        req = 2'b00;
        tick();
        total++;
        if (ack !== 2'b00 || bank[5] !== 32'hDEADBEEF || rd1 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_after got ack=%b bank5=%h rd1=%h exp 00 deadbeef deadbeef",
                     ack, bank[5], rd1);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp;
        req = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0);
        set_req(1, 1'b0, 5'd2, 5'd3, 5'd0, 32'h0);
        req = 2'b11;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c % 3 == 2)
                exp = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            else
                exp = 2'b00;
            total++;
            if (ack !== exp || en !== 1'b0) begin
                bad++;
                $display("FAIL contention_c%0d got ack=%b en=%b exp %b 0", c, ack, en, exp);
            end
        end
        total++;
        if (rd1 !== 32'h2 || rd2 !== 32'h3) begin
            bad++;
            $display("FAIL contention_rd got %h %h exp 2 3", rd1, rd2);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_zero_write();
        set_req(0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234);
        req = 2'b01;
        tick();
        total++;
        if (en !== 1'b0 || en0 !== 1'b1) begin
            bad++;
            $display("FAIL zero_enesc got prot=%b noprot=%b exp 0 1", en, en0);
        end
        tick();
        total++;
        if (ack !== 2'b01 || zd !== 1'b1) begin
            bad++;
            $display("FAIL zero_drop got ack=%b zd=%b exp 01 1", ack, zd);
        end
        total++;
        if (ack0 !== 2'b01 || zd0 !== 1'b0) begin
            bad++;
            $display("FAIL zero_noprot got ack=%b zd=%b exp 01 0", ack0, zd0);
        end
        total++;
        if (rd1 !== 32'h0 || rd1_0 !== 32'h1234) begin
            bad++;
            $display("FAIL zero_rd got prot=%h noprot=%h exp 0 1234", rd1, rd1_0);
        end
        req = 2'b00;
        tick();
        total++;
        if (zd !== 1'b0 || bank[0] !== 32'h0 || bank0[0] !== 32'h1234) begin
            bad++;
            $display("FAIL zero_bank got zd=%b b0=%h nb0=%h exp 0 0 1234", zd, bank[0], bank0[0]);
        end
    endtask

    task automatic test_read_only();
        set_req(1, 1'b0, 5'd3, 5'd7, 5'd3, 32'hFFFF);
        req = 2'b10;
        tick();
        total++;
        if (en !== 1'b0 || rr1 !== 5'd3 || rr2 !== 5'd7) begin
            bad++;
            $display("FAIL ro_issue got en=%b rr1=%0d rr2=%0d exp 0 3 7", en, rr1, rr2);
        end
        tick();
        total++;
        if (ack !== 2'b10 || rd1 !== 32'h3 || rd2 !== 32'h7) begin
            bad++;
            $display("FAIL ro_ack got ack=%b rd1=%h rd2=%h exp 10 3 7", ack, rd1, rd2);
        end
        req = 2'b00;
        tick();
        total++;
        if (bank[3] !== 32'h3) begin
            bad++;
            $display("FAIL ro_nowrite got %h exp 3", bank[3]);
        end
    endtask

    task automatic test_stale_payload();
        set_req(0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h11111111);
        req = 2'b01;
        tick();
        set_req(0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h22222222);
        total++;
        if (en !== 1'b1 || wd !== 32'h11111111) begin
            bad++;
            $display("FAIL stale_issue got en=%b wd=%h exp 1 11111111", en, wd);
        end
        tick();
        total++;
        if (ack !== 2'b01 || rd1 !== 32'h11111111) begin
            bad++;
            $display("FAIL stale_ack got ack=%b rd1=%h exp 01 11111111", ack, rd1);
        end
        req = 2'b00;
        tick();
        total++;
        if (bank[9] !== 32'h11111111) begin
            bad++;
            $display("FAIL stale_bank got %h exp 11111111", bank[9]);
        end
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b0, 5'd6, 5'd8, 5'd0, 32'h0);
        set_req(1, 1'b1, 5'd4, 5'd4, 5'd4, 32'h44444444);
        req = 2'b11;
        tick();
        total++;
        if (en !== 1'b1 || wr !== 5'd4) begin
            bad++;
            $display("FAIL rmid_issue got en=%b wr=%0d exp 1 4", en, wr);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (en !== 1'b0 || ack !== 2'b00 || wr !== 5'd0 || wd !== 32'h0 || rd1 !== 32'h0) begin
            bad++;
            $display("FAIL rmid_async got en=%b ack=%b wr=%0d wd=%h rd1=%h exp 0 00 0 0 0",
                     en, ack, wr, wd, rd1);
        end
        tick();
        total++;
        if (ack !== 2'b00) begin
            bad++;
            $display("FAIL rmid_noack got %b exp 00", ack);
        end
        rst = 1'b0;
        tick();
        total++;
        if (en !== 1'b0 || rr1 !== 5'd6) begin
            bad++;
            $display("FAIL rmid_rearb got en=%b rr1=%0d exp 0 6", en, rr1);
        end
        tick();
        total++;
        if (ack !== 2'b01 || rd1 !== 32'h6 || rd2 !== 32'h8) begin
            bad++;
            $display("FAIL rmid_ack got ack=%b rd1=%h rd2=%h exp 01 6 8", ack, rd1, rd2);
        end
        req = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_zero_write();
        test_read_only();
        test_stale_payload();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
